// File: rtl/key_input_pkg.sv
// Shared types for the push-button key scheduler: FSM states and the
// button-index to ASCII key map used when writing to the keyboard FIFO.
package key_input_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_HOLD,
      ST_RELEASE
   } state_e;

   localparam logic [6:0] ASCII_W = 7'h57;
   localparam logic [6:0] ASCII_D = 7'h44;
   localparam logic [6:0] ASCII_S = 7'h53;
   localparam logic [6:0] ASCII_A = 7'h41;

   function automatic logic [6:0] key_to_ascii(input logic [1:0] key);
      logic [6:0] code;
      case (key)
         2'd0:    code = ASCII_W;
         2'd1:    code = ASCII_D;
         2'd2:    code = ASCII_S;
         default: code = ASCII_A;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/key_input_scheduler.sv
// Debounces four buttons, arbitrates by highest index, adds auto-repeat for
// held keys and drives the keyboard FIFO write handshake.
module key_input_scheduler
   import key_input_pkg::*;
#(
   parameter int CNT_W          = 24,
   parameter int DEBOUNCE_TICKS = 100000,
   parameter int REPEAT_DELAY   = 400000,
   parameter int REPEAT_PERIOD  = 100000
) (
   input  logic       FPGA_GlobalClock,
   input  logic       rst,
   input  logic       tick_en,
   input  logic [3:0] keyboard_in,
   input  logic       fifo_full,
   input  logic       wr_ack,
   output logic       wr_en,
   output logic [6:0] din,
   output logic       busy,
   output logic [7:0] drop_count
);

   localparam longint CNT_LIMIT = longint'(1) << CNT_W;

   if (DEBOUNCE_TICKS < 1 || longint'(DEBOUNCE_TICKS) >= CNT_LIMIT ||
       REPEAT_DELAY < 1   || longint'(REPEAT_DELAY)   >= CNT_LIMIT ||
       REPEAT_PERIOD < 0  || longint'(REPEAT_PERIOD)  >= CNT_LIMIT) begin : g_param_check
      $error("key_input_scheduler: counter parameters do not fit in CNT_W");
   end

   localparam logic [CNT_W-1:0] DEB_TGT    = CNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [CNT_W-1:0] DELAY_TGT  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_TGT = CNT_W'(REPEAT_PERIOD - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cur_q, cur_d;
   logic             rep_q, rep_d;
   logic             wr_en_q, wr_en_d;
   logic [6:0]       din_q, din_d;
   logic [7:0]       drop_q, drop_d;
   logic             busy_q;

   logic [1:0]       sel;
   logic             any;
   logic [CNT_W-1:0] hold_tgt;

   always_comb begin
      if (keyboard_in[3])      sel = 2'd3;
      else if (keyboard_in[2]) sel = 2'd2;
      else if (keyboard_in[1]) sel = 2'd1;
      else                     sel = 2'd0;
   end

   assign any      = |keyboard_in;
   assign hold_tgt = rep_q ? PERIOD_TGT : DELAY_TGT;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      rep_d   = rep_q;
      wr_en_d = wr_en_q;
      din_d   = din_q;
      drop_d  = drop_q;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               cur_d   = sel;
               cnt_d   = '0;
               state_d = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!any) begin
               state_d = ST_IDLE;
            end else if (sel != cur_q) begin
               cur_d = sel;
               cnt_d = '0;
            end else if (tick_en) begin
               if (cnt_q == DEB_TGT) begin
                  rep_d   = 1'b0;
                  state_d = ST_ISSUE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            // A first press waits for FIFO space; a repeat is simply dropped.
            if (fifo_full) begin
               if (rep_q) begin
                  if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end
            end else begin
               wr_en_d = 1'b1;
               din_d   = key_to_ascii(cur_q);
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (wr_ack) begin
               wr_en_d = 1'b0;
               if (!any) begin
                  state_d = ST_IDLE;
               end else if (sel != cur_q) begin
                  state_d = ST_RELEASE;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!any) begin
               state_d = ST_IDLE;
            end else if (sel != cur_q) begin
               cur_d   = sel;
               cnt_d   = '0;
               state_d = ST_DEBOUNCE;
            end else if (REPEAT_PERIOD != 0 && tick_en) begin
               if (cnt_q == hold_tgt) begin
                  rep_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_ISSUE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_RELEASE: begin
            if (!any) begin
               state_d = ST_IDLE;
            end else begin
               cur_d   = sel;
               cnt_d   = '0;
               state_d = ST_DEBOUNCE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge FPGA_GlobalClock) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cur_q   <= 2'd0;
         rep_q   <= 1'b0;
         wr_en_q <= 1'b0;
         din_q   <= 7'd0;
         drop_q  <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         rep_q   <= rep_d;
         wr_en_q <= wr_en_d;
         din_q   <= din_d;
         drop_q  <= drop_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign wr_en      = wr_en_q;
   assign din        = din_q;
   assign busy       = busy_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_key_input_scheduler.sv
// Bench for key_input_scheduler: directed scenarios plus randomized segments,
// each clock compared against a phase/tick-count reference of the key rules.
module tb_key_input_scheduler;

   localparam int DEB = 4;
   localparam int DLY = 8;
   localparam int PER = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_en;
   logic [3:0] kb;
   logic       fifo_full;
   logic       wr_ack;
   logic       wr_en;
   logic [6:0] din;
   logic       busy;
   logic [7:0] drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   string m_phase = "idle";
   int    m_cur   = 0;
   int    m_ticks = 0;
   bit    m_rep   = 1'b0;
   bit    m_wr    = 1'b0;
   int    m_din   = 0;
   int    m_drop  = 0;

   int ack_delay = 1;
   int hi_cnt    = 0;
   bit rand_tick = 1'b0;

   key_input_scheduler #(
      .CNT_W         (24),
      .DEBOUNCE_TICKS(DEB),
      .REPEAT_DELAY  (DLY),
      .REPEAT_PERIOD (PER)
   ) dut (
      .FPGA_GlobalClock(clk),
      .rst             (rst),
      .tick_en         (tick_en),
      .keyboard_in     (kb),
      .fifo_full       (fifo_full),
      .wr_ack          (wr_ack),
      .wr_en           (wr_en),
      .din             (din),
      .busy            (busy),
      .drop_count      (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ascii_of(input int k);
      case (k)
         0:       return 'h57;
         1:       return 'h44;
         2:       return 'h53;
         default: return 'h41;
      endcase
   endfunction

   function automatic int top_key(input logic [3:0] k);
      for (int i = 3; i >= 0; i--) if (k[i]) return i;
      return -1;
   endfunction

   // Reference: phase name plus count of ticks observed in the current phase.
   task automatic model_step();
      int sel;
      bit any;
      sel = top_key(kb);
      any = (kb != 4'b0000);
      if (rst) begin
         m_phase = "idle"; m_wr = 0; m_din = 0; m_drop = 0;
         m_ticks = 0; m_rep = 0; m_cur = 0;
         return;
      end
      if (m_phase == "idle") begin
         if (any) begin m_cur = sel; m_ticks = 0; m_phase = "debounce"; end
      end else if (m_phase == "debounce") begin
         if (!any) m_phase = "idle";
         else if (sel != m_cur) begin m_cur = sel; m_ticks = 0; end
         else if (tick_en) begin
            m_ticks++;
            if (m_ticks == DEB) begin m_rep = 0; m_phase = "issue"; end
         end
      end else if (m_phase == "issue") begin
         if (fifo_full) begin
            if (m_rep) begin
               if (m_drop < 255) m_drop++;
               m_ticks = 0;
               m_phase = "hold";
            end
         end else begin
            m_wr = 1; m_din = ascii_of(m_cur); m_phase = "flight";
         end
      end else if (m_phase == "flight") begin
         if (wr_ack) begin
            m_wr = 0;
            if (!any) m_phase = "idle";
            else if (sel != m_cur) m_phase = "release";
            else begin m_ticks = 0; m_phase = "hold"; end
         end
      end else if (m_phase == "hold") begin
         if (!any) m_phase = "idle";
         else if (sel != m_cur) begin m_cur = sel; m_ticks = 0; m_phase = "debounce"; end
         else if (PER != 0 && tick_en) begin
            m_ticks++;
            if (m_ticks == (m_rep ? PER : DLY)) begin
               m_rep = 1; m_ticks = 0; m_phase = "issue";
            end
         end
      end else begin
         if (!any) m_phase = "idle";
         else begin m_cur = sel; m_ticks = 0; m_phase = "debounce"; end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("wr_en", int'(wr_en), int'(m_wr));
      check_eq("din", int'(din), m_din);
      check_eq("busy", int'(busy), int'(m_phase != "idle"));
      check_eq("drop_count", int'(drop_count), m_drop);
      if (m_wr) begin
         hi_cnt++;
         wr_ack = (hi_cnt - 1 >= ack_delay);
      end else begin
         hi_cnt = 0;
         wr_ack = ($urandom_range(7) == 0);
      end
      tick_en = rand_tick ? ($urandom_range(3) != 0) : 1'b1;
   endtask

   task automatic wait_wr_rise(input string tag);
      int n;
      bit prev;
      bit found;
      n = 0; prev = wr_en; found = 0;
      while (n < 60 && !found) begin
         cycle();
         n++;
         if (wr_en && !prev) found = 1;
         prev = wr_en;
      end
      check_eq({tag, "_seen"}, int'(found), 1);
   endtask

   initial begin
      int lat;
      int wr_cnt;
      int r;
      int len;

      rst = 1; kb = 4'b0000; fifo_full = 0; wr_ack = 0; tick_en = 1;
      repeat (3) cycle();
      check_eq("reset_wr_en", int'(wr_en), 0);
      check_eq("reset_din", int'(din), 0);
      check_eq("reset_busy", int'(busy), 0);
      check_eq("reset_drop", int'(drop_count), 0);
      rst = 0;
      repeat (2) cycle();

      // Single press: latency, key code, repeats, release
      kb = 4'b0001; lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         cycle();
         if (wr_en) lat = i;
      end
      check_eq("press_latency", lat, DEB + 2);
      check_eq("press_din", int'(din), 'h57);
      repeat (30) cycle();
      kb = 4'b0000;
      repeat (8) cycle();
      check_eq("release_busy", int'(busy), 0);

      // Bounce never produces a write
      wr_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         kb = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
         cycle();
         if (wr_en) wr_cnt++;
      end
      check_eq("bounce_writes", wr_cnt, 0);
      kb = 4'b0000;
      repeat (4) cycle();

      // Priority, then switch while holding
      kb = 4'b0110;
      wait_wr_rise("prio");
      check_eq("prio_din", int'(din), 'h53);
      repeat (4) cycle();
      kb = 4'b0010;
      wait_wr_rise("switch");
      check_eq("switch_din", int'(din), 'h44);
      kb = 4'b0000;
      repeat (8) cycle();

      // First press against a full FIFO waits, then writes
      fifo_full = 1; kb = 4'b1000;
      repeat (15) cycle();
      check_eq("full_wait_wr_en", int'(wr_en), 0);
      check_eq("full_wait_busy", int'(busy), 1);
      fifo_full = 0;
      wait_wr_rise("full_release");
      check_eq("full_release_din", int'(din), 'h41);
      repeat (4) cycle();

      // Repeats while full are dropped and the counter saturates
      fifo_full = 1; wr_cnt = 0;
      repeat (1300) begin
         cycle();
         if (wr_en) wr_cnt++;
      end
      check_eq("drop_no_writes", wr_cnt, 0);
      check_eq("drop_saturated", int'(drop_count), 255);
      fifo_full = 0; kb = 4'b0000;
      repeat (8) cycle();

      // Ack in the first wr_en cycle gives a one-cycle pulse
      ack_delay = 0; kb = 4'b0001;
      wait_wr_rise("same_cycle");
      cycle();
      check_eq("same_cycle_wr_en_low", int'(wr_en), 0);

      // Withheld ack keeps wr_en and din across release, then reset mid-handshake
      ack_delay = 1000;
      wait_wr_rise("withheld");
      kb = 4'b0000;
      repeat (10) cycle();
      check_eq("withheld_wr_en", int'(wr_en), 1);
      check_eq("withheld_din", int'(din), 'h57);
      rst = 1;
      cycle();
      check_eq("midrst_wr_en", int'(wr_en), 0);
      check_eq("midrst_busy", int'(busy), 0);
      check_eq("midrst_drop", int'(drop_count), 0);
      rst = 0; ack_delay = 1;
      repeat (2) cycle();

      // Randomized segments against the reference
      rand_tick = 1;
      for (int s = 0; s < 80; s++) begin
         r = $urandom_range(9);
         if (r < 2)      kb = 4'b0000;
         else if (r < 7) kb = 4'(1 << $urandom_range(3));
         else            kb = 4'($urandom);
         fifo_full = ($urandom_range(5) == 0);
         ack_delay = ($urandom_range(9) == 0) ? 12 : $urandom_range(3);
         len = $urandom_range(30, 1);
         repeat (len) cycle();
      end
      rand_tick = 0; kb = 4'b0000; fifo_full = 0; ack_delay = 0;
      repeat (30) cycle();
      check_eq("final_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_input_scheduler.md
# key_input_scheduler

Controller that turns the four raw push-button inputs into ASCII key events for the keyboard FIFO feeding `tetris_main`. It debounces the buttons, arbitrates simultaneous presses by fixed priority, and sequences the FIFO write handshake (`wr_en`/`wr_ack`). It also adds Tetris-style auto-repeat for held keys. It sits between the board buttons and the FIFO write port, replacing the ad-hoc hold/acknowledge logic in the top-level shell.

## Interface
Parameters:
- `CNT_W`, 24: width of the debounce and repeat counters.
- `DEBOUNCE_TICKS`, 100000: number of consecutive `tick_en` ticks a key must be stable before its first event.
- `REPEAT_DELAY`, 400000: ticks from the first event to the first repeat.
- `REPEAT_PERIOD`, 100000: ticks between later repeats. A value of 0 disables repeat.

Ports:
- `FPGA_GlobalClock`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `tick_en`, in, 1: counter advance enable (the slow tick).
- `keyboard_in`, in, 4: raw buttons, active-high.
- `fifo_full`, in, 1: the FIFO cannot accept a write.
- `wr_ack`, in, 1: the FIFO accepted the write.
- `wr_en`, out, 1: FIFO write request.
- `din`, out, 7: ASCII code to write.
- `busy`, out, 1: high in any state other than IDLE.
- `drop_count`, out, 8: saturating count of repeat events dropped because the FIFO was full.

## Operation
- **Key select (combinational):** `sel` is the highest set index of `keyboard_in`, and `any` is the OR of all four bits. The key map is 0→0x57 'W', 1→0x44 'D', 2→0x53 'S', 3→0x41 'A'.
- **FSM states:** IDLE, DEBOUNCE, ISSUE, WAIT_ACK, HOLD, RELEASE.
- **IDLE:**
  - If `any`, latch `sel` into `cur`, clear `cnt`, and go to DEBOUNCE.
- **DEBOUNCE:**
  - If `!any`, go to IDLE.
  - Else if `sel != cur`, latch the new `cur`, clear `cnt`, and stay.
  - Else on `tick_en`, `cnt++`. When `cnt == DEBOUNCE_TICKS-1` on a tick, set `rep=0` and go to ISSUE.
- **ISSUE:**
  - First event (`rep=0`) and `fifo_full`: stay in ISSUE.
  - Repeat event (`rep=1`) and `fifo_full`: `drop_count++` (saturate at 255), reload the repeat counter, and go to HOLD.
  - Otherwise, `wr_en<=1`, `din<=map[cur]`, and go to WAIT_ACK.
- **WAIT_ACK:**
  - Hold `wr_en` and `din` steady until `wr_ack` is seen.
  - On `wr_ack`, `wr_en<=0`. Then:
    - if `!any`, go to IDLE;
    - if `sel != cur`, go to RELEASE;
    - otherwise clear `cnt` and go to HOLD.
  - Key changes during WAIT_ACK never abort the handshake.
- **HOLD:**
  - If `!any`, go to IDLE.
  - If `sel != cur`, latch the new `cur`, clear `cnt`, and go to DEBOUNCE.
  - If `REPEAT_PERIOD == 0`, stay in HOLD.
  - Else on `tick_en`, `cnt++`. The target is `REPEAT_DELAY-1` after the first event and `REPEAT_PERIOD-1` after a repeat. On reaching the target, set `rep=1`, clear `cnt`, and go to ISSUE.
- **RELEASE:**
  - If `!any`, go to IDLE.
  - Otherwise latch `sel`, clear `cnt`, and go to DEBOUNCE.
- **Counters:** `cnt` is `CNT_W` bits wide, and all compares are equality compares. Parameters must fit in `CNT_W`; this is checked at elaboration.

## Timing
- Reset values: `wr_en=0`, `din=0`, `busy=0`, `drop_count=0`, state IDLE, `cnt=0`, `rep=0`.
- Reset has priority over every other event, including in the middle of a handshake. It drops `wr_en` the next cycle and drops any pending event.
- All outputs are registered.
- `wr_en` rises one clock after the ISSUE decision and falls one clock after `wr_ack` is sampled high.
- A `wr_ack` in the first cycle that `wr_en` is high is legal. In that case `wr_en` is high for exactly 1 cycle.
- One write per event; the FIFO must produce a single-cycle `wr_ack` per write.
- Press-to-`wr_en` latency is `DEBOUNCE_TICKS` ticks plus 2 clocks.
- `wr_ack` while `wr_en=0` is ignored.
- `tick_en` affects only `cnt`. The handshake and key-change checks run every clock.

## Structure
- Package `key_input_pkg` holds:
  - the state enum;
  - the four ASCII localparams;
  - a `key_to_ascii` function.
- The combinational priority select is small enough to stay inline; no sub-module is needed.

## Test plan
All scenarios use DEBOUNCE_TICKS=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, `tick_en=1`, and `wr_ack` one clock after `wr_en` unless stated otherwise.

- **Single press:** `keyboard_in=0001` held 20 clocks. Required: first `wr_en` with `din=0x57` 6 clocks after the press. Repeats follow after DELAY, then every PERIOD plus handshake cycles. Release returns to IDLE and clears `busy`.
- **Bounce:** input toggles 0001/0000 every 2 clocks. Required: no `wr_en`, ever.
- **Priority and switch:** `keyboard_in=0110` gives `din=0x53`. Changing to 0010 mid-HOLD restarts debounce, then gives `din=0x44`.
- **Full FIFO:**
  - First press with `fifo_full=1` holds in ISSUE with `wr_en=0`. Deasserting `fifo_full` gives a write.
  - Repeats while full increment `drop_count` without writing.
  - `drop_count` saturates at 255 after 300 drops.
- **Same-cycle ack and no ack:** `wr_ack` in the same cycle as `wr_en` gives a 1-cycle `wr_en`. With `wr_ack` withheld, `wr_en` stays high and `din` stays stable across key release.
- **Reset in the middle of WAIT_ACK:** `rst` pulse gives `wr_en=0` the next clock, state IDLE, and `drop_count=0`.
